pc_sequencer: RTL
=================

Name: pc_sequencer

Overview:
Parametrised next-generation program-counter and branch-target unit for our 9-bit-instruction core. It replaces the fixed parameter-coded branch LUTs with runtime-writable relative and absolute target tables. It adds a hardware return-address stack for call/return, plus halt/done handling with stall support. The unit sits between the controller and InstROM, drives the instruction address, and takes the registered zero flag from ALU_FLAGS.

Parameters:
PC_W, 16, program-counter and target width
IDX_W, 5, target-table index width; each table has 2**IDX_W entries
STK_DEPTH, 4, return-stack entries (power of two, >=2)

Ports:
CLK  in  1  clock, all state updates on rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  synchronous restart: PC<=0, done<=0, stack emptied, error flags cleared; tables kept
stall  in  1  hold all PC/stack state this cycle
br_abs  in  1  unconditional jump to abs_tbl[idx]
br_rel_z  in  1  PC += rel_tbl[idx] if zero_flag=1
br_rel_nz  in  1  PC += rel_tbl[idx] if zero_flag=0
call  in  1  push PC+1, jump to abs_tbl[idx]
ret  in  1  pop stack into PC
halt  in  1  stop fetch, raise done
zero_flag  in  1  registered ALU zero flag
idx  in  IDX_W  table lookup index
tbl_we  in  1  table write enable
tbl_sel  in  1  0=rel table, 1=abs table
tbl_widx  in  IDX_W  write index
tbl_wdata  in  PC_W  write data (rel entries are two's complement)
pc  out  PC_W  current instruction address
done  out  1  halted
stk_depth  out  $clog2(STK_DEPTH)+1  current stack occupancy
stk_ovf  out  1  sticky: call issued when stack full
stk_unf  out  1  sticky: ret issued when stack empty

Behaviour:
- Reset (reset_n=0, asynchronous): pc=0, done=0, stk_depth=0, stk_ovf=0, stk_unf=0, all table entries=0, stack contents=0.
- Table reads are combinational from idx. A write takes effect at the edge, so a same-cycle read of the written index returns the old value. Writes proceed regardless of stall, halt or done, and are ignored only while start=1.
- The PC update priority per edge is:
  1. start
  2. done already set: hold
  3. halt: done<=1, pc holds
  4. stall: hold
  5. ret
  6. call
  7. br_abs
  8. taken br_rel_z/br_rel_nz
  9. pc+1
- Lower-priority controls asserted together with a higher one are ignored.
- Relative target: pc + rel_tbl[idx], modulo 2**PC_W, wrapping silently. pc+1 also wraps from 2**PC_W-1 to 0.
- Call when not full: stack[top]<=pc+1, depth+1, pc<=abs_tbl[idx].
- Call when full: no push, depth unchanged, stk_ovf<=1, pc<=abs_tbl[idx].
- Ret when not empty: pc<=stack[top-1], depth-1.
- Ret when empty: stk_unf<=1, pc<=pc+1.
- Latency: pc reflects a control input one cycle after the edge it is sampled on. done asserts one cycle after halt is sampled. done stays high until start or reset_n.
- Asserting reset_n mid-operation clears everything immediately, including tables and any in-flight write.

Decomposition:
- Package core_pkg (shared): br_kind_e enum {BR_NONE, BR_ABS, BR_REL_Z, BR_REL_NZ, BR_CALL, BR_RET}, the decoded priority result, and localparam defaults PC_W_DEF, IDX_W_DEF, STK_DEPTH_DEF.
- One sub-module, ret_stack: parametrised LIFO with push/pop/full/empty/depth, the async active-low reset and the overflow/underflow flags.
- pc_sequencer itself holds the two target tables, the priority decode and the PC register.

Test Plan:
- Reset and sequential fetch: hold reset_n=0, release, run 5 cycles with no controls -> pc goes 0,1,2,3,4,5 with done=0 and all flags 0.
- Relative branches: write rel_tbl[3]=-2 (16'hFFFE), then at pc=10 assert br_rel_nz with idx=3 and zero_flag=0 -> pc=8. Repeat with zero_flag=1 -> pc=11. Write rel_tbl[3]=5 at pc=16'hFFFE and take the branch -> pc=3 (wrap).
- Write/read same cycle: tbl_we to abs_tbl[7]=100 together with br_abs idx=7 while the old value is 0 -> pc=0. A br_abs idx=7 on the next cycle -> pc=100.
- Call/return nesting with STK_DEPTH=4: abs_tbl[1]=50. Four calls from pc=10,51,51,51 -> depth=4. A fifth call -> stk_ovf=1, depth=4, pc=50. Four rets -> pc=52,52,52,11. A fifth ret -> stk_unf=1, pc=12.
- Priority and stall: ret+call+br_abs together with depth=1 and top entry=20 -> pc=20 and depth=0. stall+br_abs together -> pc unchanged. halt+stall together -> done=1 the next cycle and pc frozen for 10 cycles.
- Restart and mid-run reset: after done=1, pulse start -> pc=0, done=0, flags cleared, abs_tbl[1] still 50. Drop reset_n between clock edges -> pc=0 and abs_tbl[1]=0 immediately.

Source files
------------

// File: rtl/core_pkg.sv
// Shared types for the program-counter sequencer: branch kinds, the decoded
// per-edge action and the control priority decoder.
package core_pkg;

    localparam int PC_W_DEF      = 16;
    localparam int IDX_W_DEF     = 5;
    localparam int STK_DEPTH_DEF = 4;

    typedef enum logic [2:0] {
        BR_NONE,
        BR_ABS,
        BR_REL_Z,
        BR_REL_NZ,
        BR_CALL,
        BR_RET
    } br_kind_e;

    typedef enum logic [2:0] {
        ACT_START,
        ACT_HOLD,
        ACT_HALT,
        ACT_STALL,
        ACT_RUN
    } pc_act_e;

    typedef struct packed {
        pc_act_e  act;
        br_kind_e kind;
    } pc_dec_t;

    // Resolves simultaneous controls; only the highest-priority one survives.
    function automatic pc_dec_t decode_ctrl(
        input logic start,
        input logic done,
        input logic halt,
        input logic stall,
        input logic ret,
        input logic call,
        input logic br_abs,
        input logic br_rel_z,
        input logic br_rel_nz,
        input logic zero_flag
    );
        pc_dec_t dec;
        dec.act  = ACT_RUN;
        dec.kind = BR_NONE;
        if (start)                       dec.act  = ACT_START;
        else if (done)                   dec.act  = ACT_HOLD;
        else if (halt)                   dec.act  = ACT_HALT;
        else if (stall)                  dec.act  = ACT_STALL;
        else if (ret)                    dec.kind = BR_RET;
        else if (call)                   dec.kind = BR_CALL;
        else if (br_abs)                 dec.kind = BR_ABS;
        else if (br_rel_z && zero_flag)  dec.kind = BR_REL_Z;
        else if (br_rel_nz && !zero_flag) dec.kind = BR_REL_NZ;
        return dec;
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Controller-facing bundle of the sequencer: branch/stack controls, table
// write port, and the fetch address / status outputs.
interface pc_sequencer_if
    import core_pkg::*;
#(
    parameter int PC_W      = PC_W_DEF,
    parameter int IDX_W     = IDX_W_DEF,
    parameter int STK_DEPTH = STK_DEPTH_DEF
);
    localparam int DEP_W = $clog2(STK_DEPTH) + 1;

    logic             start;
    logic             stall;
    logic             br_abs;
    logic             br_rel_z;
    logic             br_rel_nz;
    logic             call;
    logic             ret;
    logic             halt;
    logic             zero_flag;
    logic [IDX_W-1:0] idx;
    logic             tbl_we;
    logic             tbl_sel;
    logic [IDX_W-1:0] tbl_widx;
    logic [PC_W-1:0]  tbl_wdata;
    logic [PC_W-1:0]  pc;
    logic             done;
    logic [DEP_W-1:0] stk_depth;
    logic             stk_ovf;
    logic             stk_unf;

    modport master (
        output start, stall, br_abs, br_rel_z, br_rel_nz, call, ret, halt,
        output zero_flag, idx, tbl_we, tbl_sel, tbl_widx, tbl_wdata,
        input  pc, done, stk_depth, stk_ovf, stk_unf
    );

    modport slave (
        input  start, stall, br_abs, br_rel_z, br_rel_nz, call, ret, halt,
        input  zero_flag, idx, tbl_we, tbl_sel, tbl_widx, tbl_wdata,
        output pc, done, stk_depth, stk_ovf, stk_unf
    );

endinterface

// File: rtl/ret_stack.sv
// Return-address LIFO with occupancy count and sticky overflow/underflow flags.
module ret_stack #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic                   CLK,
    input  logic                   reset_n,
    input  logic                   clr,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           push_data,
    output logic [W-1:0]           top_data,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] depth,
    output logic                   ovf,
    output logic                   unf
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int DEP_W = PTR_W + 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [W-1:0]     mem_d [DEPTH];
    logic [DEP_W-1:0] depth_q, depth_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             full;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    assign full   = (depth_q == DEP_W'(DEPTH));
    assign empty  = (depth_q == '0);
    assign wr_ptr = depth_q[PTR_W-1:0];
    assign rd_ptr = wr_ptr - PTR_W'(1);

    always_comb begin
        mem_d   = mem_q;
        depth_d = depth_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        if (clr) begin
            depth_d = '0;
            ovf_d   = 1'b0;
            unf_d   = 1'b0;
        end else if (push) begin
            if (full) begin
                ovf_d = 1'b1;
            end else begin
                mem_d[wr_ptr] = push_data;
                depth_d       = depth_q + DEP_W'(1);
            end
        end else if (pop) begin
            if (empty) unf_d   = 1'b1;
            else       depth_d = depth_q - DEP_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            mem_q   <= '{default: '0};
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            mem_q   <= mem_d;
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign top_data = mem_q[rd_ptr];
    assign depth    = depth_q;
    assign ovf      = ovf_q;
    assign unf      = unf_q;

endmodule

// File: rtl/pc_sequencer.sv
// Program counter with runtime-writable relative/absolute branch tables,
// call/return stack and halt/done handling.
module pc_sequencer
    import core_pkg::*;
#(
    parameter int PC_W      = PC_W_DEF,
    parameter int IDX_W     = IDX_W_DEF,
    parameter int STK_DEPTH = STK_DEPTH_DEF
) (
    input  logic           CLK,
    input  logic           reset_n,
    pc_sequencer_if.slave  bus
);
    localparam int ENTRIES = 2 ** IDX_W;
    localparam int DEP_W   = $clog2(STK_DEPTH) + 1;

    logic [PC_W-1:0]  rel_tbl_q [ENTRIES];
    logic [PC_W-1:0]  rel_tbl_d [ENTRIES];
    logic [PC_W-1:0]  abs_tbl_q [ENTRIES];
    logic [PC_W-1:0]  abs_tbl_d [ENTRIES];
    logic [PC_W-1:0]  pc_q, pc_d;
    logic             done_q, done_d;
    logic [PC_W-1:0]  pc_inc, rel_tgt, abs_tgt;
    pc_dec_t          dec;
    logic             stk_push, stk_pop, stk_clr, stk_empty;
    logic [PC_W-1:0]  stk_top;
    logic [DEP_W-1:0] stk_depth;
    logic             stk_ovf, stk_unf;

    // Reads use the pre-edge table contents, so a same-cycle write is not seen.
    assign pc_inc  = pc_q + PC_W'(1);
    assign rel_tgt = pc_q + rel_tbl_q[bus.idx];
    assign abs_tgt = abs_tbl_q[bus.idx];

    always_comb begin
        rel_tbl_d = rel_tbl_q;
        abs_tbl_d = abs_tbl_q;
        if (bus.tbl_we && !bus.start) begin
            if (bus.tbl_sel) abs_tbl_d[bus.tbl_widx] = bus.tbl_wdata;
            else             rel_tbl_d[bus.tbl_widx] = bus.tbl_wdata;
        end
    end

    always_comb begin
        dec = decode_ctrl(bus.start, done_q, bus.halt, bus.stall, bus.ret,
                          bus.call, bus.br_abs, bus.br_rel_z, bus.br_rel_nz,
                          bus.zero_flag);
        pc_d     = pc_q;
        done_d   = done_q;
        stk_push = 1'b0;
        stk_pop  = 1'b0;
        stk_clr  = 1'b0;
        unique case (dec.act)
            ACT_START: begin
                pc_d    = '0;
                done_d  = 1'b0;
                stk_clr = 1'b1;
            end
            ACT_HALT: done_d = 1'b1;
            ACT_RUN: begin
                unique case (dec.kind)
                    BR_RET: begin
                        stk_pop = 1'b1;
                        pc_d    = stk_empty ? pc_inc : stk_top;
                    end
                    BR_CALL: begin
                        stk_push = 1'b1;
                        pc_d     = abs_tgt;
                    end
                    BR_ABS:              pc_d = abs_tgt;
                    BR_REL_Z, BR_REL_NZ: pc_d = rel_tgt;
                    default:             pc_d = pc_inc;
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            rel_tbl_q <= '{default: '0};
            abs_tbl_q <= '{default: '0};
            pc_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            rel_tbl_q <= rel_tbl_d;
            abs_tbl_q <= abs_tbl_d;
            pc_q      <= pc_d;
            done_q    <= done_d;
        end
    end

    ret_stack #(
        .W     (PC_W),
        .DEPTH (STK_DEPTH)
    ) u_ret_stack (
        .CLK       (CLK),
        .reset_n   (reset_n),
        .clr       (stk_clr),
        .push      (stk_push),
        .pop       (stk_pop),
        .push_data (pc_inc),
        .top_data  (stk_top),
        .empty     (stk_empty),
        .depth     (stk_depth),
        .ovf       (stk_ovf),
        .unf       (stk_unf)
    );

    assign bus.pc        = pc_q;
    assign bus.done      = done_q;
    assign bus.stk_depth = stk_depth;
    assign bus.stk_ovf   = stk_ovf;
    assign bus.stk_unf   = stk_unf;

endmodule
